// File: rtl/dpwm_pkg.sv
// Shared defaults and helpers for the digital PWM.
//   DEF_REF_W   default width of the duty reference
//   DEF_PERIOD  default PWM period in clocks
//   DEF_CNT_W   default counter width (must hold DEF_PERIOD-1)
//   saturate()  clamps a reference to the period length
package dpwm_pkg;

  localparam int DEF_REF_W  = 4;
  localparam int DEF_PERIOD = 10;
  localparam int DEF_CNT_W  = 4;

  // Any reference at or beyond the period means "high for the whole period".
  function automatic int unsigned saturate(input int unsigned ref_v,
                                           input int unsigned period);
    return (ref_v >= period) ? period : ref_v;
  endfunction

endpackage

// File: rtl/dpwm_counter.sv
// Modulo-PERIOD free-running counter with synchronous active-high reset.
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high; forces cnt to 0
//   cnt    out  current count, 0 .. PERIOD-1
//   wrap   out  high while cnt == PERIOD-1 (last clock of the period)
module dpwm_counter
  import dpwm_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_p0;

  assign wrap = (cnt_p0 == CNT_W'(PERIOD - 1));

  // Stage p0: period position
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= '0;
    end else if (wrap) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign cnt = cnt_p0;

endmodule

// File: rtl/dpwm.sv
// Digital pulse-width modulator. One pulse per PERIOD clocks whose high
// time equals the saturated reference; the output is registered.
//   f_in      in   clock, rising edge
//   reset     in   synchronous, active-high
//   Ref       in   duty reference (clocks high per period), REF_W bits
//   Signal_o  out  registered PWM output
// Build option: define DPWM_SHADOW_REF_EN to load the reference into a
// shadow register at each period boundary, so a Ref change only takes effect
// at the start of the next period (first period after reset is all-low).
// Undefined: the saturated reference feeds the compare directly.
module dpwm
  import dpwm_pkg::*;
#(
  parameter int REF_W  = DEF_REF_W,
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             f_in,
  input  logic             reset,
  input  logic [REF_W-1:0] Ref,
  output logic             Signal_o
);

  // One extra bit so a duty of exactly PERIOD is representable.
  localparam int DUTY_W = CNT_W + 1;

  logic [CNT_W-1:0]  cnt_p0;
  logic              wrap_p0;
  logic [DUTY_W-1:0] duty_sat;
  logic [DUTY_W-1:0] duty_eff;
  logic              pwm_p1;

  dpwm_counter #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clk   (f_in),
    .reset (reset),
    .cnt   (cnt_p0),
    .wrap  (wrap_p0)
  );

  assign duty_sat = DUTY_W'(saturate(32'(Ref), 32'(PERIOD)));

`ifdef DPWM_SHADOW_REF_EN
  logic [DUTY_W-1:0] duty_shadow;

  // Loaded on the last clock of a period so the new duty lines up with cnt=0.
  always_ff @(posedge f_in) begin
    if (reset) begin
      duty_shadow <= '0;
    end else if (wrap_p0) begin
      duty_shadow <= duty_sat;
    end
  end

  assign duty_eff = duty_shadow;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_p0;
  assign duty_eff    = duty_sat;
`endif

  // Stage p1: registered compare. duty_eff=PERIOD keeps every cnt below it,
  // so the output holds high across the wrap with no gap.
  always_ff @(posedge f_in) begin
    if (reset) begin
      pwm_p1 <= 1'b0;
    end else begin
      pwm_p1 <= ({1'b0, cnt_p0} < duty_eff);
    end
  end

  assign Signal_o = pwm_p1;

endmodule

// File: tb/tb_dpwm.sv
`timescale 1ns/1ps
module tb_dpwm;

  localparam int P = 10;
`ifdef DPWM_SHADOW_REF_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       f_in = 1'b0;
  logic       reset;
  logic [3:0] Ref;
  logic       Signal_o;

  dpwm #(.REF_W(4), .PERIOD(P), .CNT_W(4)) dut (
    .f_in     (f_in),
    .reset    (reset),
    .Ref      (Ref),
    .Signal_o (Signal_o)
  );

  always #1000 f_in = ~f_in;

  int   n_assert = 0;
  int   n_fail   = 0;
  // Reference model: clocks elapsed since reset release, and the duty that
  // was latched at the last period boundary.
  int   t = 0;
  int   shadow_duty = 0;
  logic expected;
  logic win[$];

  function automatic int sat(input int r);
    return (r >= P) ? P : r;
  endfunction

  // Apply inputs for one clock, predict the output seen after the edge.
  task automatic step(input int r, input logic rs);
    int pos;
    int eff;
    Ref   = 4'(r);
    reset = rs;
    if (rs) begin
      expected    = 1'b0;
      t           = 0;
      shadow_duty = 0;
    end else begin
      pos      = t % P;
      eff      = SHADOW ? shadow_duty : sat(r);
      expected = (pos < eff);
      if (pos == P - 1) shadow_duty = sat(r);
      t++;
    end
    @(posedge f_in);
    #1;
    n_assert++;
    assert (Signal_o === expected) else begin
      n_fail++;
      $error("FAIL sig t=%0d ref=%0d rst=%0b observed=%b expected=%b",
             t, r, rs, Signal_o, expected);
    end
    win.push_back(Signal_o);
    if (win.size() > P) void'(win.pop_front());
  endtask

  // Any P consecutive samples cover one full period: high count = duty.
  task automatic check_window(input int duty);
    int highs;
    highs = 0;
    foreach (win[i]) highs += int'(win[i]);
    n_assert++;
    assert (highs == duty && win.size() == P) else begin
      n_fail++;
      $error("FAIL window observed_highs=%0d samples=%0d expected_highs=%0d",
             highs, win.size(), duty);
    end
  endtask

  task automatic run(input int r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
    check_window(sat(r));
  endtask

  initial begin
    reset = 1'b1;
    Ref   = 4'd9;
    for (int i = 0; i < 3; i++) step(9, 1'b1);

    run(9, 30);
    run(1, 30);
    run(5, 30);
    run(0, 25);
    run(10, 25);
    run(15, 25);

    // Reference change 2 -> 3 at cnt=4
    run(2, 20);
    while (t % P != 4) step(2, 1'b0);
    run(3, 25);

    // Reset mid-period at cnt=6
    run(9, 20);
    while (t % P != 6) step(9, 1'b0);
    step(9, 1'b1);
    run(9, 25);

    // Random reference with occasional resets
    for (int seg = 0; seg < 120; seg++) begin
      int r;
      int len;
      r   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(r, 1'b1);
      end
      for (int k = 0; k < len; k++) step(r, 1'b0);
    end
    run(7, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
